vga_timing_gen: RTL

- Parametrised successor to the fixed 640x480 sync counter that drives the VGA debug screen.
- Generates H/V timing from parameters, with selectable sync polarity and a pixel-enable clock gate.
- Produces character-cell coordinates (cell column/row, pixel-in-cell, linear cell index) through incremental counters, with no dividers or multipliers.
- Delays hsync/vsync/de by a programmable number of stages so they line up with downstream ROM latency.

---
 rtl/vga_pkg.sv | 44 ++++
 rtl/vga_delay_line.sv | 50 +++++
 rtl/vga_timing_gen.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// vga_pkg : VGA timing presets, sync bundle type and total-length helper
// Rev 1.0
// ============================================================================
package vga_pkg;

  // 640x480@60, 25.175 MHz pixel clock
  localparam int VGA640_H_VISIBLE = 640;
  localparam int VGA640_H_FRONT   = 16;
  localparam int VGA640_H_SYNC    = 96;
  localparam int VGA640_H_BACK    = 48;
  localparam int VGA640_V_VISIBLE = 480;
  localparam int VGA640_V_FRONT   = 10;
  localparam int VGA640_V_SYNC    = 2;
  localparam int VGA640_V_BACK    = 33;
  localparam bit VGA640_HSYNC_ACTIVE = 1'b0;
  localparam bit VGA640_VSYNC_ACTIVE = 1'b0;

  // 1280x1024@60, 108 MHz board clock
  localparam int VGA1280_H_VISIBLE = 1280;
  localparam int VGA1280_H_FRONT   = 48;
  localparam int VGA1280_H_SYNC    = 112;
  localparam int VGA1280_H_BACK    = 248;
  localparam int VGA1280_V_VISIBLE = 1024;
  localparam int VGA1280_V_FRONT   = 1;
  localparam int VGA1280_V_SYNC    = 3;
  localparam int VGA1280_V_BACK    = 38;
  localparam bit VGA1280_HSYNC_ACTIVE = 1'b1;
  localparam bit VGA1280_VSYNC_ACTIVE = 1'b1;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } vga_sync_t;

  function automatic int vga_total(input int visible, input int front,
                                   input int sync, input int back);
    return visible + front + sync + back;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ============================================================================
// vga_delay_line : DEPTH-stage enable-gated register pipe, DEPTH=0 is a wire
// Rev 1.0
// ============================================================================
module vga_delay_line #(
  parameter int               DEPTH   = 1,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, reset, en, RST_VAL};
    assign q = d;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
      stage_d = stage_q;
      if (en) begin
        stage_d[0] = d;
        for (int i = 1; i < DEPTH; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= RST_VAL;
        end
      end else begin
        stage_q <= stage_d;
      end
    end

    assign q = stage_q[DEPTH-1];
  end

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// vga_timing_gen : parametrised VGA sync counter with character-cell coordinates
// Rev 1.0
// ============================================================================
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE    = VGA640_H_VISIBLE,
  parameter int H_FRONT      = VGA640_H_FRONT,
  parameter int H_SYNC       = VGA640_H_SYNC,
  parameter int H_BACK       = VGA640_H_BACK,
  parameter int V_VISIBLE    = VGA640_V_VISIBLE,
  parameter int V_FRONT      = VGA640_V_FRONT,
  parameter int V_SYNC       = VGA640_V_SYNC,
  parameter int V_BACK       = VGA640_V_BACK,
  parameter bit HSYNC_ACTIVE = VGA640_HSYNC_ACTIVE,
  parameter bit VSYNC_ACTIVE = VGA640_VSYNC_ACTIVE,
  parameter int CELL_W       = 8,
  parameter int CELL_H       = 16,
  parameter int COLS         = 80,
  parameter int SYNC_DELAY   = 1,
  parameter int COORD_W      = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [COORD_W-1:0] cell_col,
  output logic [COORD_W-1:0] cell_row,
  output logic [COORD_W-1:0] cell_index,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               line_start,
  output logic               frame_start
);

  localparam int H_TOTAL = vga_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = vga_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  if (CELL_W < 1) begin : g_err_cell_w
    $error("vga_timing_gen: CELL_W must be >= 1");
  end
  if (CELL_H < 1) begin : g_err_cell_h
    $error("vga_timing_gen: CELL_H must be >= 1");
  end
  if (COLS < 1) begin : g_err_cols
    $error("vga_timing_gen: COLS must be >= 1");
  end
  if (H_TOTAL >= (1 << COORD_W) || V_TOTAL >= (1 << COORD_W)) begin : g_err_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in COORD_W");
  end
  if (SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_err_delay
    $error("vga_timing_gen: SYNC_DELAY must be 0..4");
  end

  localparam logic [COORD_W-1:0] c_h_last   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] c_v_last   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] c_cw_last  = COORD_W'(CELL_W - 1);
  localparam logic [COORD_W-1:0] c_ch_last  = COORD_W'(CELL_H - 1);
  localparam logic [COORD_W-1:0] c_cols     = COORD_W'(COLS);
  localparam logic [COORD_W-1:0] c_h_vis    = COORD_W'(H_VISIBLE);
  localparam logic [COORD_W-1:0] c_v_vis    = COORD_W'(V_VISIBLE);
  localparam logic [COORD_W-1:0] c_hs_start = COORD_W'(H_VISIBLE + H_FRONT);
  localparam logic [COORD_W-1:0] c_hs_end   = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [COORD_W-1:0] c_vs_start = COORD_W'(V_VISIBLE + V_FRONT);
  localparam logic [COORD_W-1:0] c_vs_end   = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [COORD_W-1:0] cell_col_q, cell_col_d, cell_row_q, cell_row_d;
  logic [COORD_W-1:0] row_base_q, row_base_d;
  logic               w_x_last, w_y_last;

  assign w_x_last = (x_q == c_h_last);
  assign w_y_last = (y_q == c_v_last);

  // Cell coordinates are tracked incrementally; row_base carries cell_row*COLS.
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    pix_x_d    = pix_x_q;
    pix_y_d    = pix_y_q;
    cell_col_d = cell_col_q;
    cell_row_d = cell_row_q;
    row_base_d = row_base_q;
    if (en) begin
      if (w_x_last) begin
        x_d        = '0;
        pix_x_d    = '0;
        cell_col_d = '0;
        if (w_y_last) begin
          y_d        = '0;
          pix_y_d    = '0;
          cell_row_d = '0;
          row_base_d = '0;
        end else begin
          y_d = y_q + 1'b1;
          if (pix_y_q == c_ch_last) begin
            pix_y_d    = '0;
            cell_row_d = cell_row_q + 1'b1;
            row_base_d = row_base_q + c_cols;
          end else begin
            pix_y_d = pix_y_q + 1'b1;
          end
        end
      end else begin
        x_d = x_q + 1'b1;
        if (pix_x_q == c_cw_last) begin
          pix_x_d    = '0;
          cell_col_d = cell_col_q + 1'b1;
        end else begin
          pix_x_d = pix_x_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q        <= '0;
      y_q        <= '0;
      pix_x_q    <= '0;
      pix_y_q    <= '0;
      cell_col_q <= '0;
      cell_row_q <= '0;
      row_base_q <= '0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      pix_x_q    <= pix_x_d;
      pix_y_q    <= pix_y_d;
      cell_col_q <= cell_col_d;
      cell_row_q <= cell_row_d;
      row_base_q <= row_base_d;
    end
  end

  vga_sync_t w_raw, w_dly;

  assign w_raw.hs = ((x_q >= c_hs_start) && (x_q < c_hs_end)) ? HSYNC_ACTIVE : !HSYNC_ACTIVE;
  assign w_raw.vs = ((y_q >= c_vs_start) && (y_q < c_vs_end)) ? VSYNC_ACTIVE : !VSYNC_ACTIVE;
  assign w_raw.de = (x_q < c_h_vis) && (y_q < c_v_vis);

  vga_delay_line #(
    .DEPTH   (SYNC_DELAY),
    .WIDTH   ($bits(vga_sync_t)),
    .RST_VAL ({!HSYNC_ACTIVE, !VSYNC_ACTIVE, 1'b0})
  ) u_sync_dly (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .d     (w_raw),
    .q     (w_dly)
  );

  assign x           = x_q;
  assign y           = y_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign cell_col    = cell_col_q;
  assign cell_row    = cell_row_q;
  assign cell_index  = row_base_q + cell_col_q;
  assign hsync       = w_dly.hs;
  assign vsync       = w_dly.vs;
  assign de          = w_dly.de;
  assign line_start  = en && (x_q == '0);
  assign frame_start = en && (x_q == '0) && (y_q == '0);

endmodule
`default_nettype wire
